// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants and the fetch FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs; flush empties it in one cycle.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues credit-limited in-order imem reads, buffers
// returned words and discards responses made stale by a ctrl redirect.
module ifetch
  import riscv_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int             DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t      state_reg, state_next;
  logic [XLEN-1:0]   fetch_pc_reg;
  logic [CW-1:0]     inflight_reg, inflight_next;
  logic [CW-1:0]     drop_reg, drop_next;
  logic [CW-1:0]     count;
  logic [XLEN+31:0]  head;
  logic [31:0]       last_instr_reg;
  logic [XLEN-1:0]   last_pc_reg;
  logic [XLEN-1:0]   target_aligned;
  logic              req_fire, instr_fire, redirect, rsp_ok, push;

  assign target_aligned = PCTarget & ~XLEN'(3);
  assign imem_req_valid = (state_reg == RUN) && ((int'(inflight_reg) + int'(count)) < DEPTH);
  assign imem_req_addr  = fetch_pc_reg;
  assign instr_valid    = (count != '0);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign instr_fire     = instr_valid && instr_ready;
  assign redirect       = instr_fire && PCSrc;
  // A response with nothing outstanding belongs to no request (e.g. one issued before reset).
  assign rsp_ok         = imem_rsp_valid && (inflight_reg != '0);
  assign push           = rsp_ok && (state_reg == RUN) && !redirect;
  assign inflight_next  = inflight_reg + CW'(req_fire) - CW'(rsp_ok);

  always_comb begin
    state_next = state_reg;
    drop_next  = drop_reg;
    case (state_reg)
      IDLE: state_next = RUN;
      RUN: begin
        if (redirect) begin
          drop_next  = inflight_next;
          state_next = (inflight_next != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (rsp_ok && drop_reg != '0) drop_next = drop_reg - CW'(1);
        if (drop_next == '0) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      inflight_reg   <= '0;
      drop_reg       <= '0;
      last_instr_reg <= '0;
      last_pc_reg    <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
      if (redirect)      fetch_pc_reg <= target_aligned;
      else if (req_fire) fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
      if (instr_valid) begin
        last_instr_reg <= head[31:0];
        last_pc_reg    <= head[XLEN+31:32];
      end
    end
  end

  ifetch_fifo #(
    .WIDTH(XLEN + 32),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (instr_fire),
    .flush(redirect),
    .din  ({fetch_pc_of_rsp(), imem_rsp_data}),
    .dout (head),
    .count(count)
  );

  // PC of the returning word: requests are in order, so it trails fetch_pc by the
  // number of requests still outstanding.
  function automatic logic [XLEN-1:0] fetch_pc_of_rsp();
    return fetch_pc_reg - (XLEN'(inflight_reg) << 2);
  endfunction

  assign instr    = instr_valid ? head[31:0] : last_instr_reg;
  assign instr_pc = instr_valid ? head[XLEN+31:32] : last_pc_reg;
  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[30];

  assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> inflight_reg != '0);

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed vector table plus randomized memory/ctrl
// traffic checked against a program-order PC model.
module tb_ifetch;
  import riscv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;

  always #5 clk = ~clk;

  ifetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .op(op), .funct3(funct3), .funct7(funct7)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic rdy; logic rv; logic [31:0] ra; logic iv; logic [31:0] ipc; logic [6:0] iop;
  } vec_t;

  mreq_t       memq[$];
  vec_t        tbl[8];
  int          cyc = 0, n_checks = 0, n_fail = 0, consumed = 0, req_acc = 0;
  int          rdy_pct = 100, req_rdy_pct = 100, pcsrc_pct = 0, lat_min = 1, lat_max = 1;
  logic [31:0] exp_pc = '0, exp_req = '0, last_pc = '0;
  bit          force_en = 0;
  logic [31:0] force_pc = '0, force_tgt = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [6:0] o;
    case (a[4:2])
      3'd0: o = OP_IMM;
      3'd1: o = OP_RTYPE;
      3'd2: o = OP_LOAD;
      3'd3: o = OP_STORE;
      3'd4: o = OP_BRANCH;
      3'd5: o = OP_JAL;
      3'd6: o = OP_IMM;
      default: o = OP_RTYPE;
    endcase
    return {a[26:2], o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] w;
    w = word_at(exp_pc);
    if (instr_valid) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, w);
      chk("op", {25'b0, op}, {25'b0, w[6:0]});
      chk("funct3", {29'b0, funct3}, {29'b0, w[14:12]});
      chk("funct7", {31'b0, funct7}, {31'b0, w[30]});
    end
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
    chk("credit", {31'b0, memq.size() <= DEPTH}, 32'd1);
  endtask

  task automatic drive();
    instr_ready    = ($urandom_range(99) < rdy_pct);
    imem_req_ready = ($urandom_range(99) < req_rdy_pct);
    PCSrc          = ($urandom_range(99) < pcsrc_pct);
    PCTarget       = $urandom;
    if (force_en && instr_valid && instr_pc == force_pc) begin
      instr_ready = 1'b1;
      PCSrc       = 1'b1;
      PCTarget    = force_tgt;
      force_en    = 0;
    end
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (imem_req_valid && imem_req_ready) begin
      memq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      exp_req = exp_req + 32'd4;
      req_acc++;
    end
    if (instr_valid && instr_ready) begin
      consumed++;
      last_pc = instr_pc;
      $display("instr pc=%h word=%h redirect=%0d target=%h", instr_pc, instr, PCSrc, PCTarget);
      if (PCSrc) begin
        exp_pc  = PCTarget & ~32'd3;
        exp_req = exp_pc;
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    drive();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    instr_ready = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; PCSrc = 1'b0;
    memq.delete();
    force_en = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    end
    rst = 1'b0;
    exp_pc = '0;
    exp_req = '0;
  endtask

  task automatic run_consume(input int n, input int budget, input string name);
    int start = consumed;
    int k = 0;
    while ((consumed - start) < n && k < budget) begin
      step();
      k++;
    end
    chk(name, {31'b0, (consumed - start) >= n}, 32'd1);
  endtask

  initial begin
    int k;
    int start;
    tbl[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 7'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 7'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0, 7'b0010011};
    tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4, 7'b0110011};
    tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0, 7'h0};
    tbl[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h8, 7'b0000011};
    tbl[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 7'b0100011};
    tbl[7] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h0, 7'h0};

    // Reset and fill/stream timing with a 1-cycle memory.
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_model();
      chk("tbl_req_valid", {31'b0, imem_req_valid}, {31'b0, tbl[i].rv});
      if (tbl[i].rv) chk("tbl_req_addr", imem_req_addr, tbl[i].ra);
      chk("tbl_instr_valid", {31'b0, instr_valid}, {31'b0, tbl[i].iv});
      if (tbl[i].iv) begin
        chk("tbl_instr_pc", instr_pc, tbl[i].ipc);
        chk("tbl_op", {25'b0, op}, {25'b0, tbl[i].iop});
      end
      rdy_pct = tbl[i].rdy ? 100 : 0;
      drive();
    end

    // Backpressure: only DEPTH requests may be issued while the head is held.
    do_reset(2);
    rdy_pct = 0;
    req_acc = 0;
    repeat (8) step();
    chk("bp_reqs", req_acc, DEPTH);
    chk("bp_head_valid", {31'b0, instr_valid}, 32'd1);
    chk("bp_head_pc", instr_pc, 32'h0);
    rdy_pct = 100;
    run_consume(6, 40, "bp_release");

    // Redirect at PC 0x8 to 0x40 with slow memory so stale responses are in flight.
    do_reset(2);
    lat_min = 3; lat_max = 3;
    force_en = 1; force_pc = 32'h8; force_tgt = 32'h40;
    run_consume(3, 60, "redir_reach");
    chk("redir_at_pc", last_pc, 32'h8);
    run_consume(1, 60, "redir_follow");
    chk("redir_pc", last_pc, 32'h40);

    // Random traffic: redirects coinciding with responses and request accepts.
    lat_min = 1; lat_max = 3; rdy_pct = 70; req_rdy_pct = 80; pcsrc_pct = 20;
    start = consumed;
    repeat (1500) step();
    chk("stress_progress", {31'b0, (consumed - start) > 100}, 32'd1);

    // Reset while draining stale responses, then restart and PC wrap.
    lat_min = 6; lat_max = 6; rdy_pct = 100; req_rdy_pct = 100; pcsrc_pct = 0;
    do_reset(2);
    force_en = 1; force_pc = 32'h4; force_tgt = 32'h100;
    k = 0;
    while (force_en && k < 50) begin
      step();
      k++;
    end
    chk("drain_redirect_done", {31'b0, force_en}, 32'd0);
    chk("drain_stale_pending", {31'b0, memq.size() > 0}, 32'd1);
    do_reset(2);
    lat_min = 1; lat_max = 1;
    @(negedge clk);
    chk("restart_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("restart_req_addr", imem_req_addr, 32'h0);
    check_model();
    drive();
    run_consume(3, 60, "restart_fetch");
    force_en = 1; force_pc = 32'hC; force_tgt = 32'hFFFF_FFF8;
    run_consume(4, 80, "wrap_fetch");
    chk("wrap_pc", last_pc, 32'h0);
    run_consume(2, 40, "wrap_continue");
    chk("wrap_next_pc", last_pc, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
